// File: rtl/sifh_peak_finder_pkg.sv
// Shared constants, derived widths and scan-state encodings for the SiFH peak finder.
package sifh_peak_finder_pkg;

  // Histogram RAM geometry and count width
  localparam int SIFH_NB                = 5;
  localparam int SIFH_PEAK_MAX          = 8;
  localparam int SIFH_BIN_NUM_PER_HIS   = 16;
  localparam int SIFH_PIXEL_NUM_PER_RAM = 2;

  // Index widths; a single-pixel RAM still gets a one-bit pixel index
  localparam int SIFH_NBIN = $clog2(SIFH_BIN_NUM_PER_HIS);
  localparam int SIFH_NPIX = (SIFH_PIXEL_NUM_PER_RAM > 1) ? $clog2(SIFH_PIXEL_NUM_PER_RAM) : 1;

  // Scan controller states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_OUT   = 3'd3,
    ST_DONE  = 3'd4
  } sifh_state_e;

endpackage

// File: rtl/sifh_peak_finder_argmax_acc.sv
// Pipelined argmax accumulator: tracks the peak bin and its count over one pixel's
// read stream. Ties keep the lower bin; bin 0 of each pixel loads unconditionally.
module sifh_argmax_acc
  import sifh_peak_finder_pkg::*;
#(
  parameter int NBIN     = SIFH_NBIN,
  parameter int PEAK_MAX = SIFH_PEAK_MAX
) (
  input  logic                clk,
  input  logic                res,
  input  logic                rv_i,
  input  logic [NBIN-1:0]     rbin_i,
  input  logic [PEAK_MAX-1:0] counts_i,
  input  logic                acc_clr_i,
  output logic [NBIN-1:0]     max_bin_o,
  output logic [PEAK_MAX-1:0] max_cnt_o
);

  logic [NBIN-1:0]     max_bin_q, max_bin_d;
  logic [PEAK_MAX-1:0] max_cnt_q, max_cnt_d;

  // Next max: clear on result accept, load on first bin or strictly greater count
  always_comb begin
    max_bin_d = max_bin_q;
    max_cnt_d = max_cnt_q;
    if (acc_clr_i) begin
      max_bin_d = {NBIN{1'b0}};
      max_cnt_d = {PEAK_MAX{1'b0}};
    end else if (rv_i && ((rbin_i == {NBIN{1'b0}}) || (counts_i > max_cnt_q))) begin
      max_bin_d = rbin_i;
      max_cnt_d = counts_i;
    end else begin
      max_bin_d = max_bin_q;
      max_cnt_d = max_cnt_q;
    end
  end

  // Max registers
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      max_bin_q <= {NBIN{1'b0}};
      max_cnt_q <= {PEAK_MAX{1'b0}};
    end else begin
      max_bin_q <= max_bin_d;
      max_cnt_q <= max_cnt_d;
    end
  end

  assign max_bin_o = max_bin_q;
  assign max_cnt_o = max_cnt_q;

endmodule

// File: rtl/sifh_peak_finder.sv
// SiFH peak finder: scans the histogram RAM pixel by pixel, reports each pixel's
// peak bin on a valid/ready port and optionally zeroes every bin behind the read.
module sifh_peak_finder
  import sifh_peak_finder_pkg::*;
#(
  parameter int NB       = SIFH_NB,
  parameter int PEAK_MAX = SIFH_PEAK_MAX,
  parameter int BIN_NUM  = SIFH_BIN_NUM_PER_HIS,
  parameter int PIX_NUM  = SIFH_PIXEL_NUM_PER_RAM,
  parameter int NPIX     = SIFH_NPIX,
  parameter int NBIN     = SIFH_NBIN
) (
  input  logic                clk,
  input  logic                res,
  input  logic                start,
  input  logic                clear_en,
  input  logic [PEAK_MAX-1:0] counts,
  output logic [NB-1:0]       raddr,
  output logic                rd_en,
  output logic [NB-1:0]       waddr,
  output logic                wr_en,
  output logic [PEAK_MAX-1:0] wdata,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [NPIX-1:0]     res_pixel,
  output logic [NBIN-1:0]     res_bin,
  output logic [PEAK_MAX-1:0] res_count,
  output logic                busy,
  output logic                done
);

  localparam logic [NBIN-1:0] LAST_BIN = NBIN'(BIN_NUM - 1);
  localparam logic [NPIX-1:0] LAST_PIX = NPIX'(PIX_NUM - 1);

  sifh_state_e         state_q;
  logic [NB-1:0]       addr_q;
  logic [NBIN-1:0]     bin_q;
  logic [NPIX-1:0]     pix_q;
  logic                clr_q;
  logic                rd_en_q;
  logic                res_valid_q;
  logic                busy_q;
  logic                done_q;

  // Read pipeline: one cycle behind the issued address
  logic                rv_q;
  logic [NBIN-1:0]     rbin_q;
  logic [NB-1:0]       rd_addr_q;
  logic                wr_en_q;

  logic                acc_clr_s;
  logic [NBIN-1:0]     max_bin_s;
  logic [PEAK_MAX-1:0] max_cnt_s;

  // The running max is dropped exactly when a result is handed over
  assign acc_clr_s = (state_q == ST_OUT) && res_ready;

  // Scan controller; addr is a free-running counter so pixels sit back to back
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q     <= ST_IDLE;
      addr_q      <= {NB{1'b0}};
      bin_q       <= {NBIN{1'b0}};
      pix_q       <= {NPIX{1'b0}};
      clr_q       <= 1'b0;
      rd_en_q     <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_q  <= {NB{1'b0}};
            bin_q   <= {NBIN{1'b0}};
            pix_q   <= {NPIX{1'b0}};
            clr_q   <= clear_en;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_SCAN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          addr_q <= addr_q + NB'(1);
          if (bin_q == LAST_BIN) begin
            rd_en_q <= 1'b0;
            state_q <= ST_DRAIN;
          end else begin
            bin_q <= bin_q + NBIN'(1);
          end
        end
        ST_DRAIN: begin
          // Last bin's data is absorbed by the accumulator on this edge
          res_valid_q <= 1'b1;
          state_q     <= ST_OUT;
        end
        ST_OUT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            if (pix_q == LAST_PIX) begin
              state_q <= ST_DONE;
            end else begin
              pix_q   <= pix_q + NPIX'(1);
              bin_q   <= {NBIN{1'b0}};
              rd_en_q <= 1'b1;
              state_q <= ST_SCAN;
            end
          end else begin
            state_q <= ST_OUT;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Read-data alignment and clear-behind write; write address always trails the read
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      rv_q      <= 1'b0;
      rbin_q    <= {NBIN{1'b0}};
      rd_addr_q <= {NB{1'b0}};
      wr_en_q   <= 1'b0;
    end else begin
      rv_q      <= rd_en_q;
      rbin_q    <= bin_q;
      rd_addr_q <= addr_q;
      wr_en_q   <= rd_en_q & clr_q;
    end
  end

  sifh_argmax_acc #(
    .NBIN     (NBIN),
    .PEAK_MAX (PEAK_MAX)
  ) u_acc (
    .clk       (clk),
    .res       (res),
    .rv_i      (rv_q),
    .rbin_i    (rbin_q),
    .counts_i  (counts),
    .acc_clr_i (acc_clr_s),
    .max_bin_o (max_bin_s),
    .max_cnt_o (max_cnt_s)
  );

  assign raddr     = addr_q;
  assign rd_en     = rd_en_q;
  assign waddr     = rd_addr_q;
  assign wr_en     = wr_en_q;
  assign wdata     = {PEAK_MAX{1'b0}};
  assign res_valid = res_valid_q;
  assign res_pixel = pix_q;
  assign res_bin   = max_bin_s;
  assign res_count = max_cnt_s;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sifh_peak_finder.sv
// Directed, table-driven bench for sifh_peak_finder with a behavioural histogram RAM.
module tb_sifh_peak_finder;

  logic       clk;
  logic       res;
  logic       start;
  logic       clear_en;
  logic [7:0] counts;
  logic [4:0] raddr;
  logic       rd_en;
  logic [4:0] waddr;
  logic       wr_en;
  logic [7:0] wdata;
  logic       res_valid;
  logic       res_ready;
  logic [0:0] res_pixel;
  logic [3:0] res_bin;
  logic [7:0] res_count;
  logic       busy;
  logic       done;

  sifh_peak_finder dut (
    .clk       (clk),
    .res       (res),
    .start     (start),
    .clear_en  (clear_en),
    .counts    (counts),
    .raddr     (raddr),
    .rd_en     (rd_en),
    .waddr     (waddr),
    .wr_en     (wr_en),
    .wdata     (wdata),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_pixel (res_pixel),
    .res_bin   (res_bin),
    .res_count (res_count),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Histogram RAM model: one-cycle read latency, bulk load from pat[]
  logic [7:0] mem [0:31];
  logic [7:0] pat [0:31];
  logic       load_en = 1'b0;
  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 32; i++) mem[i] <= pat[i];
    end else begin
      if (wr_en) mem[waddr] <= wdata;
      if (rd_en) counts <= mem[raddr];
    end
  end

  // Write log: each write must hit the address read in the previous cycle, with data 0
  int         wr_q[$];
  int         wr_bad = 0;
  logic       prev_rd_en = 1'b0;
  logic [4:0] prev_raddr = 5'd0;
  always @(negedge clk) begin
    if (wr_en) begin
      wr_q.push_back(int'(waddr));
      if (!(prev_rd_en && prev_raddr == waddr) || wdata != 8'd0) wr_bad++;
    end
    prev_rd_en = rd_en;
    prev_raddr = raddr;
  end

  logic [63:0] all_out;
  assign all_out = {28'd0, raddr, rd_en, waddr, wr_en, wdata, res_valid, res_pixel,
                    res_bin, res_count, busy, done};

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] p0_bin; logic [7:0] p0_val; logic [7:0] p0_bg; logic [3:0] p0_bin2;
    logic [3:0] p1_bin; logic [7:0] p1_val; logic [7:0] p1_bg; logic [3:0] p1_bin2;
    logic [3:0] e0_bin; logic [7:0] e0_cnt; logic [3:0] e1_bin; logic [7:0] e1_cnt;
  } vec_t;

  vec_t vecs [5];

  int       start_cyc, done_cyc;
  int       vcyc [2];
  int       acyc [2];
  logic [0:0] got_pix [2];
  logic [3:0] got_bin [2];
  logic [7:0] got_cnt [2];

  task automatic load_pattern(input vec_t v);
    for (int b = 0; b < 16; b++) begin
      pat[b]      = (b == int'(v.p0_bin) || b == int'(v.p0_bin2)) ? v.p0_val : v.p0_bg;
      pat[16 + b] = (b == int'(v.p1_bin) || b == int'(v.p1_bin2)) ? v.p1_val : v.p1_bg;
    end
    @(negedge clk); load_en = 1'b1;
    @(negedge clk); load_en = 1'b0;
  endtask

  // One full two-pixel scan; bp>0 holds pixel 0 for bp cycles, mid pulses start while busy
  task automatic run_scan(input logic clr, input int bp, input logic mid);
    int n;
    logic [12:0] snap;
    wr_q.delete();
    wr_bad = 0;
    clear_en  = clr;
    res_ready = (bp == 0);
    @(negedge clk); start = 1'b1; start_cyc = cyc;
    @(negedge clk); start = 1'b0; clear_en = 1'b0;
    check("busy_after_start", busy, 1);
    for (int p = 0; p < 2; p++) begin
      n = 0;
      while (res_valid !== 1'b1 && n < 100) begin
        @(negedge clk); n++;
        if (mid && p == 0) start = (n == 5);
      end
      start = 1'b0;
      check("res_valid_seen", res_valid, 1);
      vcyc[p] = cyc;
      got_pix[p] = res_pixel; got_bin[p] = res_bin; got_cnt[p] = res_count;
      if (p == 0 && bp > 0) begin
        snap = {res_pixel, res_bin, res_count};
        for (int k = 0; k < bp; k++) begin
          @(negedge clk);
          check("bp_hold", {res_valid, rd_en, wr_en, res_pixel, res_bin, res_count},
                {3'b100, snap});
        end
        res_ready = 1'b1;
        acyc[p] = cyc;
        @(negedge clk);
        check("bp_resume_read", {rd_en, raddr}, {1'b1, 5'd16});
      end else begin
        acyc[p] = cyc;
        @(negedge clk);
      end
    end
    n = 0;
    while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("done_seen", done, 1);
    done_cyc = cyc;
    check("busy_low_at_done", busy, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    res_ready = 1'b0;
  endtask

  task automatic check_res(input logic [3:0] b0, input logic [7:0] c0,
                           input logic [3:0] b1, input logic [7:0] c1);
    check("pix0_index", got_pix[0], 0);
    check("pix0_bin",   got_bin[0], b0);
    check("pix0_count", got_cnt[0], c0);
    check("pix1_index", got_pix[1], 1);
    check("pix1_bin",   got_bin[1], b1);
    check("pix1_count", got_cnt[1], c1);
    check("lat_first",  vcyc[0] - start_cyc, 18);
    check("lat_next",   vcyc[1] - acyc[0], 18);
    check("done_lat",   done_cyc - acyc[1], 2);
  endtask

  initial begin
    int n;
    // p0: bin, val, bg, bin2 | p1: bin, val, bg, bin2 | expected bin0, cnt0, bin1, cnt1
    vecs[0] = '{4'd7, 8'd42,  8'd3,   4'd7,  4'd2,  8'd9,   8'd0,   4'd2,  4'd7,  8'd42,  4'd2,  8'd9};
    vecs[1] = '{4'd4, 8'd255, 8'd0,   4'd11, 4'd0,  8'd200, 8'd199, 4'd15, 4'd4,  8'd255, 4'd0,  8'd200};
    vecs[2] = '{4'd0, 8'd0,   8'd0,   4'd0,  4'd15, 8'd128, 8'd127, 4'd15, 4'd0,  8'd0,   4'd15, 8'd128};
    vecs[3] = '{4'd0, 8'd5,   8'd4,   4'd0,  4'd1,  8'd254, 8'd253, 4'd1,  4'd0,  8'd5,   4'd1,  8'd254};
    vecs[4] = '{4'd9, 8'd250, 8'd1,   4'd9,  4'd3,  8'd0,   8'd0,   4'd3,  4'd9,  8'd250, 4'd0,  8'd0};

    res = 1'b0; start = 1'b0; clear_en = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_out, 64'd0);
    res = 1'b1;
    @(negedge clk);

    // Table: plain scans, no clear, ready held high
    for (int i = 0; i < 5; i++) begin
      load_pattern(vecs[i]);
      run_scan(1'b0, 0, 1'b0);
      check_res(vecs[i].e0_bin, vecs[i].e0_cnt, vecs[i].e1_bin, vecs[i].e1_cnt);
      check("no_writes_without_clear", wr_q.size(), 0);
    end

    // Clear enabled: same results, then 32 zero writes in address order
    load_pattern(vecs[0]);
    run_scan(1'b1, 0, 1'b0);
    check_res(4'd7, 8'd42, 4'd2, 8'd9);
    check("clear_write_count", wr_q.size(), 32);
    for (int i = 0; i < 32; i++) begin
      if (i < wr_q.size()) check("clear_write_addr", wr_q[i], i);
    end
    check("clear_write_timing", wr_bad, 0);
    run_scan(1'b0, 0, 1'b0);
    check_res(4'd0, 8'd0, 4'd0, 8'd0);

    // Back-pressure on pixel 0 for 10 cycles
    load_pattern(vecs[1]);
    run_scan(1'b0, 10, 1'b0);
    check_res(4'd4, 8'd255, 4'd0, 8'd200);
    check("bp_no_writes", wr_q.size(), 0);

    // Reset in the middle of a scan, at bin 5 of pixel 0
    load_pattern(vecs[0]);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!(rd_en === 1'b1 && raddr == 5'd5) && n < 30) begin @(negedge clk); n++; end
    check("reached_bin5", {rd_en, raddr}, {1'b1, 5'd5});
    res = 1'b0;
    #1;
    check("midscan_reset_outputs", all_out, 64'd0);
    @(negedge clk); res = 1'b1;
    #1;
    check("after_release_outputs", all_out, 64'd0);
    repeat (3) @(negedge clk);
    check("idle_after_reset", {busy, rd_en, res_valid}, 3'b000);

    // Fresh run with a start pulse while busy that must be ignored
    run_scan(1'b0, 0, 1'b1);
    check_res(4'd7, 8'd42, 4'd2, 8'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
